// File: rtl/aer_in_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aer_in_receiver
//  Purpose  : 4-phase AER input port; pushes spike events into the input FIFO,
//             acknowledges and counts other event types as dropped.
//  Revision : 1.0
// ============================================================================
module aer_in_receiver #(
   parameter int N     = 256,
   parameter int M     = 8,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             enable_i,
   input  logic [M+1:0]     AER_ADDR_i,
   input  logic             AER_REQ_i,
   output logic             AER_ACK_o,
   input  logic             FIFO_full_i,
   output logic             FIFO_w_en_o,
   output logic [M-1:0]     FIFO_w_data_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] spike_cnt_o,
   output logic [CNT_W-1:0] drop_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PUSH = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [1:0]       c_TYPE_SPIKE = 2'b00;
   localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   generate
      if (N != (1 << M)) begin : g_bad_n
         $error("aer_in_receiver: N must equal 2**M");
      end
   endgenerate

   state_t           r_state;
   logic             r_req_meta;
   logic             r_req_s;
   logic [M-1:0]     r_addr;
   logic             r_ack;
   logic [CNT_W-1:0] r_spike_cnt;
   logic [CNT_W-1:0] r_drop_cnt;
   logic             w_push_ok;

   // REQ is asynchronous to CLK; the address bundle is only read once r_req_s is high
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_req_meta <= 1'b0;
         r_req_s    <= 1'b0;
      end else begin
         r_req_meta <= AER_REQ_i;
         r_req_s    <= r_req_meta;
      end
   end

   assign w_push_ok = (r_state == ST_PUSH) && !FIFO_full_i;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_ack       <= 1'b0;
         r_spike_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack <= 1'b0;
               if (r_req_s && enable_i) begin
                  r_addr <= AER_ADDR_i[M-1:0];
                  if (AER_ADDR_i[M+1:M] == c_TYPE_SPIKE) begin
                     r_state <= ST_PUSH;
                  end else begin
                     r_state    <= ST_ACK;
                     r_ack      <= 1'b1;
                     r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
                  end
               end
            end
            ST_PUSH: begin
               if (!FIFO_full_i) begin
                  r_state     <= ST_ACK;
                  r_ack       <= 1'b1;
                  r_spike_cnt <= r_spike_cnt + c_CNT_ONE;
               end
            end
            ST_ACK: begin
               if (!r_req_s) begin
                  r_state <= ST_IDLE;
                  r_ack   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ack   <= 1'b0;
            end
         endcase
      end
   end

   assign AER_ACK_o     = r_ack;
   assign FIFO_w_en_o   = w_push_ok;
   assign FIFO_w_data_o = r_addr;
   assign busy_o        = (r_state != ST_IDLE);
   assign spike_cnt_o   = r_spike_cnt;
   assign drop_cnt_o    = r_drop_cnt;

endmodule
`default_nettype wire
